// File: rtl/seq_mul_pkg.sv
// ----------------------------------------------------------------------------
// seq_mul_pkg
// Shared types and helpers for the iterative shift-add multiplier.
//   seq_mul_state_t : control FSM states (IDLE, CALC, DONE)
//   cnt_w(w)        : width of a counter that must hold the values 0..w
// ----------------------------------------------------------------------------
package seq_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } seq_mul_state_t;

   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_mul_add.sv
// ----------------------------------------------------------------------------
// seq_mul_add
// WIDTH-bit adder with carry-out; the single adder shared by every
// partial-product step of seq_mul_iter.
// Ports:
//   x, y  in  WIDTH  addends
//   sum   out WIDTH  x + y (low WIDTH bits)
//   cout  out 1      carry out of the top bit
// ----------------------------------------------------------------------------
module seq_mul_add #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/seq_mul_iter.sv
// ----------------------------------------------------------------------------
// seq_mul_iter
// Sequential shift-add multiplier: one partial-product step per clock,
// W-bit operands, 2W-bit product, signed or unsigned per operation.
// Operands are converted to magnitudes on accept, multiplied unsigned, and
// the sign is applied on the final step.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   in_valid     operands/mode presented     in_ready   accepting operands
//   a, b         multiplicand / multiplier    is_signed  1 = two's complement
//   out_valid    product holds a result       out_ready  consumer takes it
//   product      2W-bit result                busy       not idle
//
// Build option:
//   SEQ_MUL_EARLY_TERM_EN - when defined, CALC finishes as soon as every
//   multiplier bit still to be consumed is zero, using a barrel shift to
//   align the accumulator in that final step.
// ----------------------------------------------------------------------------
module seq_mul_iter
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = cnt_w(WIDTH);

   seq_mul_state_t   state, state_nxt;

   logic [WIDTH-1:0] mag_a;      // captured |a|
   logic             neg;        // result must be negated
   logic [PW-1:0]    acc;        // {partial product, unconsumed multiplier bits}
   logic [CW-1:0]    cnt;        // steps remaining

   logic             accept;
   logic [WIDTH-1:0] a_mag_in, b_mag_in;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic [PW-1:0]    step_acc;
   logic [PW-1:0]    prod_nxt;
   logic             last_step;

   assign accept = in_valid & in_ready;

   // Magnitudes of the incoming operands. For -2^(W-1) the two's-complement
   // negate wraps back to 2^(W-1), which is the correct unsigned magnitude.
   always_comb begin
      a_mag_in = (is_signed & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      b_mag_in = (is_signed & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
   end

   seq_mul_add #(.WIDTH(WIDTH)) u_add (
      .x    (acc[PW-1:WIDTH]),
      .y    (mag_a),
      .sum  (add_sum),
      .cout (add_cout)
   );

`ifdef SEQ_MUL_EARLY_TERM_EN
   logic [PW-1:0] rem_mask;
`endif

   // One shift-add step; the carry re-enters at the top as the accumulator
   // shifts right, so the high half never loses a bit.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      step_acc  = acc[0] ? {add_cout, add_sum, acc[WIDTH-1:1]} : (acc >> 1);
      last_step = (cnt == CW'(1));
`ifdef SEQ_MUL_EARLY_TERM_EN
      // The low cnt bits of acc are the multiplier bits not yet consumed.
      // If they are all zero, no further adds can happen: align and finish.
      rem_mask = (PW'(1) << cnt) - PW'(1);
      if ((acc & rem_mask) == '0) begin
         step_acc  = acc >> cnt;
         last_step = 1'b1;
      end
`endif
      prod_nxt = neg ? (~step_acc + PW'(1)) : step_acc;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = CALC;
         CALC:    if (last_step) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // ---------------- Datapath ----------------
   // NOTE: sequential state is written with non-blocking assignments so all
   // registers update together from values sampled before the edge.
   // NOTE: datapath registers are reset too, so a reset mid-operation leaves
   // product at 0 and no stale partial result can ever be observed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_a   <= '0;
         neg     <= 1'b0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (accept) begin
         mag_a <= a_mag_in;
         neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
         acc   <= {{WIDTH{1'b0}}, b_mag_in};
         cnt   <= CW'(WIDTH);
      end else if (state == CALC) begin
         acc <= step_acc;
         cnt <= last_step ? '0 : cnt - CW'(1);
         if (last_step) product <= prod_nxt;
      end
   end

endmodule

// File: tb/tb_seq_mul_iter.sv
// ----------------------------------------------------------------------------
// tb_seq_mul_iter
// Self-checking bench for seq_mul_iter: a 32-bit instance for the main
// directed/random traffic and an 8-bit instance for the corner operands.
// Expected products and latencies are queued when an operation is accepted
// and compared when the result is presented.
// ----------------------------------------------------------------------------
module tb_seq_mul_iter;

   logic        clk = 1'b0;
   logic        rst_n;

   // 32-bit instance
   logic        in_valid, in_ready, is_signed, out_valid, out_ready, busy;
   logic [31:0] a, b;
   logic [63:0] product;

   // 8-bit instance
   logic        v8, r8, s8, ov8, or8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   int          vectors = 0;
   int          miscompares = 0;

   logic [63:0] sb_q[$];
   int          lat_q[$];

   always #5 clk = ~clk;

   seq_mul_iter #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .is_signed(is_signed),
      .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .busy(busy)
   );

   seq_mul_iter #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v8), .in_ready(r8),
      .a(a8), .b(b8), .is_signed(s8),
      .out_valid(ov8), .out_ready(or8),
      .product(p8), .busy(busy8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] golden(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
      logic [63:0] ex, ey;
      ex = s ? {{32{x[31]}}, x} : {32'b0, x};
      ey = s ? {{32{y[31]}}, y} : {32'b0, y};
      return ex * ey;
   endfunction

   function automatic int exp_lat(input logic [31:0] y, input logic s);
`ifdef SEQ_MUL_EARLY_TERM_EN
      logic [31:0] m;
      int          k;
      m = (s && y[31]) ? (32'd0 - y) : y;
      if (m == 32'd0) return 1;
      k = 0;
      for (int i = 0; i < 32; i++) if (m[i]) k = i;
      return (k + 2 > 32) ? 32 : k + 2;
`else
      return 32 + 0 * int'({y[0], s});
`endif
   endfunction

   // Present one operation, wait for acceptance, queue its expectations.
   // Ends on the falling edge just after the accepting edge.
   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", {63'b0, in_ready}, 64'd1);
      a = x; b = y; is_signed = s; in_valid = 1'b1;
      @(posedge clk);
      sb_q.push_back(golden(x, y, s));
      lat_q.push_back(exp_lat(y, s));
      @(negedge clk);
      // Operands change right after acceptance; the result must not care.
      in_valid = 1'b0;
      a = $urandom; b = $urandom; is_signed = ~s;
   endtask

   // Wait for the result, optionally stall the consumer, then take it.
   // Must be called straight after issue().
   task automatic collect(input string tag, input int hold);
      int          n = 0;
      logic [63:0] exp_p;
      int          exp_l;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      exp_p = sb_q.pop_front();
      exp_l = lat_q.pop_front();
      check({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
      check({tag, "_lat"}, 64'(n), 64'(exp_l));
      check({tag, "_prod"}, product, exp_p);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
         @(negedge clk);
         check({tag, "_hold_prod"}, product, exp_p);
         check({tag, "_hold_rdy"}, {62'b0, in_ready, out_valid}, 64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_after_hs"}, {62'b0, in_ready, out_valid}, 64'd2);
      check({tag, "_after_prod"}, product, exp_p);
   endtask

   task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y,
                      input logic s, input logic [15:0] exp);
      int n = 0;
      @(negedge clk);
      a8 = x; b8 = y; s8 = s; v8 = 1'b1;
      @(negedge clk);
      v8 = 1'b0; a8 = 8'h5a; b8 = 8'ha5;
      while (!ov8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, {63'b0, ov8}, 64'd1);
      check({tag, "_prod"}, {48'b0, p8}, {48'b0, exp});
      or8 = 1'b1;
      @(negedge clk);
      or8 = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; is_signed = 1'b0;
      v8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ctrl", {61'b0, in_ready, out_valid, busy}, 64'd4);
      check("rst_prod", product, 64'd0);
      rst_n = 1'b1;

      // Directed 32-bit cases
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("max_unsigned_exp", sb_q[0], 64'hFFFF_FFFE_0000_0001);
      collect("max_unsigned", 0);
      issue(32'hFFFF_FFFD, 32'd7, 1'b1);
      collect("neg3x7", 0);
      issue(32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b1);
      collect("neg3xneg7", 0);
      issue(32'h8000_0000, 32'h8000_0000, 1'b1);
      collect("minxmin", 0);
      issue(32'd5, 32'd0, 1'b0);
      collect("b_zero", 0);
      issue(32'd5, 32'd1, 1'b0);
      collect("b_one", 0);

      // Back-pressure: 10 stalled cycles with in_valid hammering
      issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      collect("backpressure", 10);
      repeat (3) @(negedge clk);
      check("bp_no_capture", {62'b0, busy, out_valid}, 64'd0);

      // Asynchronous reset in the middle of CALC
      issue(32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);
      repeat (4) @(negedge clk);
      check("mid_busy", {63'b0, busy}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ctrl", {61'b0, in_ready, out_valid, busy}, 64'd4);
      check("mid_rst_prod", product, 64'd0);
      void'(sb_q.pop_back());
      void'(lat_q.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      issue(32'd6, 32'd7, 1'b0);
      check("six_seven_exp", sb_q[0], 64'd42);
      collect("six_seven", 0);

      // Random traffic, some with short multipliers
      for (int i = 0; i < 24; i++) begin
         logic [31:0] x, y;
         logic        s;
         x = $urandom;
         y = $urandom;
         s = 1'($urandom_range(0, 1));
         if (i % 3 == 0) y = y >> $urandom_range(0, 31);
         issue(x, y, s);
         collect("rand", 0);
      end

      // 8-bit corner operands
      op8("w8_sgn_min2", 8'h80, 8'h80, 1'b1, 16'h4000);
      op8("w8_uns_80sq", 8'h80, 8'h80, 1'b0, 16'h4000);
      op8("w8_min_x1",   8'h80, 8'h01, 1'b1, 16'hFF80);
      op8("w8_uns_max",  8'hFF, 8'hFF, 1'b0, 16'hFE01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
